// File: rtl/fir_output_stage_pkg.sv
// Shared definitions for the FIR output stage: accumulator width, saturation
// limits and the {I,Q} sample-pair view at the default output width.
package fir_output_stage_pkg;

  // Width of the accumulator finalOutI/finalOutQ results.
  localparam int ACC_W = 56;

  // Default delivered sample width.
  localparam int OUT_W_DEF = 24;

  // One FIFO entry at the default width: I in the upper half, Q in the lower half.
  typedef struct packed {
    logic signed [OUT_W_DEF-1:0] i;
    logic signed [OUT_W_DEF-1:0] q;
  } iq_pair_t;

  // Largest value representable in a signed w-bit sample, on the rounding grid.
  function automatic logic signed [ACC_W:0] sat_hi(input int w);
    logic signed [ACC_W:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest value representable in a signed w-bit sample, on the rounding grid.
  function automatic logic signed [ACC_W:0] sat_lo(input int w);
    logic signed [ACC_W:0] one;
    one    = '0;
    one[0] = 1'b1;
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Single-clock FIFO holding rounded {I,Q} pairs between the rounding
// pipeline and the downstream sink. Pointers carry a wrap bit so that
// full and empty are distinguishable without a separate counter.
module fir_out_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  // Accept a write when there is room, or when a read frees a slot on the same edge.
  always_comb begin
    rd_en    = rd && !empty;
    wr_en    = wr && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_output_stage.sv
// Receiving end of the accumulator output interface. Accumulator results are
// rounded (round-half-up), saturated to OUT_W bits, buffered in a FIFO and
// drained to the sink on a push/stop handshake. The accumulator cannot be
// stalled, so overflow and saturation are reported through sticky flags.
module fir_output_stage
  import fir_output_stage_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = 24,
  parameter int SHIFT = 24,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pushIn,
  input  logic signed [IN_W-1:0]      dataInI,
  input  logic signed [IN_W-1:0]      dataInQ,
  input  logic                        stopIn,
  output logic                        pushOut,
  output logic signed [OUT_W-1:0]     dataOutI,
  output logic signed [OUT_W-1:0]     dataOutQ,
  output logic                        ovfErr,
  output logic                        satErr,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_hi(OUT_W));
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_lo(OUT_W));

  // Sign-extend by one bit so adding the half-LSB cannot wrap, then shift arithmetically.
  function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] half;
    ext           = {x[IN_W-1], x};
    half          = '0;
    half[SHIFT-1] = 1'b1;
    return (ext + half) >>> SHIFT;
  endfunction

  function automatic logic clips(input logic signed [EXT_W-1:0] r);
    return (r > SAT_HI) || (r < SAT_LO);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [EXT_W-1:0] r);
    if (r > SAT_HI) return SAT_HI[OUT_W-1:0];
    if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  logic                     vld_p0_q, vld_p0_d;
  logic signed [EXT_W-1:0]  rnd_i_p0_q, rnd_i_p0_d;
  logic signed [EXT_W-1:0]  rnd_q_p0_q, rnd_q_p0_d;
  logic                     vld_p1_q, vld_p1_d;
  logic signed [OUT_W-1:0]  sat_i_p1_q, sat_i_p1_d;
  logic signed [OUT_W-1:0]  sat_q_p1_q, sat_q_p1_d;
  logic                     push_out_q, push_out_d;
  logic signed [OUT_W-1:0]  data_out_i_q, data_out_i_d;
  logic signed [OUT_W-1:0]  data_out_q_q, data_out_q_d;
  logic                     sat_err_q, sat_err_d;
  logic                     ovf_err_q, ovf_err_d;

  logic                     fifo_rd;
  logic                     fifo_full, fifo_empty;
  logic [2*OUT_W-1:0]       fifo_wdata, fifo_rdata;
  logic                     clip_p0;
  logic                     drop;

  assign fifo_wdata = {sat_i_p1_q, sat_q_p1_q};

  fir_out_fifo #(
    .WIDTH (2*OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (vld_p1_q),
    .wdata (fifo_wdata),
    .rd    (fifo_rd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Next-state for the round stage, saturate stage, read issue and sticky flags.
  always_comb begin
    // p0: round and shift the raw accumulator results
    vld_p0_d   = pushIn;
    rnd_i_p0_d = round_shift(dataInI);
    rnd_q_p0_d = round_shift(dataInQ);
    // p1: clip into the output range
    clip_p0    = vld_p0_q && (clips(rnd_i_p0_q) || clips(rnd_q_p0_q));
    vld_p1_d   = vld_p0_q;
    sat_i_p1_d = saturate(rnd_i_p0_q);
    sat_q_p1_d = saturate(rnd_q_p0_q);
    // FIFO read issue and output register
    fifo_rd      = !fifo_empty && !stopIn;
    drop         = vld_p1_q && fifo_full && !fifo_rd;
    push_out_d   = fifo_rd;
    data_out_i_d = data_out_i_q;
    data_out_q_d = data_out_q_q;
    if (fifo_rd) begin
      data_out_i_d = fifo_rdata[2*OUT_W-1:OUT_W];
      data_out_q_d = fifo_rdata[OUT_W-1:0];
    end
    sat_err_d = sat_err_q || clip_p0;
    ovf_err_d = ovf_err_q || drop;
  end

  // Control state: valids, output handshake, delivered sample and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      push_out_q   <= 1'b0;
      data_out_i_q <= '0;
      data_out_q_q <= '0;
      sat_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      push_out_q   <= push_out_d;
      data_out_i_q <= data_out_i_d;
      data_out_q_q <= data_out_q_d;
      sat_err_q    <= sat_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Pipeline data registers; meaning is carried by the valids, so no reset.
  always_ff @(posedge clk) begin
    rnd_i_p0_q <= rnd_i_p0_d;
    rnd_q_p0_q <= rnd_q_p0_d;
    sat_i_p1_q <= sat_i_p1_d;
    sat_q_p1_q <= sat_q_p1_d;
  end

  assign pushOut  = push_out_q;
  assign dataOutI = data_out_i_q;
  assign dataOutQ = data_out_q_q;
  assign satErr   = sat_err_q;
  assign ovfErr   = ovf_err_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage: rounding, latency, saturation,
// overflow, backpressure, full-with-read and mid-burst reset.
module tb_fir_output_stage;

  localparam int IN_W  = 56;
  localparam int OUT_W = 24;
  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    pushIn = 1'b0;
  logic                    stopIn = 1'b0;
  logic signed [IN_W-1:0]  dataInI = '0;
  logic signed [IN_W-1:0]  dataInQ = '0;
  logic                    pushOut;
  logic signed [OUT_W-1:0] dataOutI;
  logic signed [OUT_W-1:0] dataOutQ;
  logic                    ovfErr;
  logic                    satErr;
  logic [LVL_W-1:0]        level;

  int checks = 0;
  int failures = 0;

  logic               stop_at_edge = 1'b0;
  int                 stop_viol = 0;
  logic [2*OUT_W-1:0] out_q[$];

  fir_output_stage #(
    .IN_W (IN_W), .OUT_W (OUT_W), .SHIFT (24), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .pushIn (pushIn), .dataInI (dataInI),
    .dataInQ (dataInQ), .stopIn (stopIn), .pushOut (pushOut),
    .dataOutI (dataOutI), .dataOutQ (dataOutQ), .ovfErr (ovfErr),
    .satErr (satErr), .level (level)
  );

  always #5 clk = ~clk;

  // Remember stopIn as seen by each rising edge.
  always @(posedge clk) stop_at_edge <= stopIn;

  // Collect every delivered sample and any delivery following a stopped edge.
  always @(negedge clk) begin
    if (pushOut) begin
      out_q.push_back({dataOutI, dataOutQ});
      if (stop_at_edge) stop_viol <= stop_viol + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [IN_W-1:0] mk(input int n);
    return IN_W'(n) <<< 24;
  endfunction

  task automatic push(input logic signed [IN_W-1:0] di, input logic signed [IN_W-1:0] dq);
    pushIn  = 1'b1;
    dataInI = di;
    dataInQ = dq;
    tick();
    pushIn  = 1'b0;
  endtask

  task automatic do_reset();
    pushIn = 1'b0;
    stopIn = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (pushOut !== 1'b0) begin failures++; $display("FAIL rst_pushOut got=%0b exp=0", pushOut); end
    checks++; if (dataOutI !== 24'sd0 || dataOutQ !== 24'sd0) begin failures++; $display("FAIL rst_data got=%0d/%0d exp=0/0", dataOutI, dataOutQ); end
    checks++; if (ovfErr !== 1'b0 || satErr !== 1'b0) begin failures++; $display("FAIL rst_flags got ovf=%0b sat=%0b exp=0/0", ovfErr, satErr); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    reset = 1'b0;
  endtask

  task automatic test_rounding();
    logic signed [IN_W-1:0] a;
    logic signed [IN_W-1:0] half;
    half = mk(1) >>> 1;
    a = 56'sd3;
    a = a <<< 23;
    push(a, half - 56'sd1);
    tick();
    tick();
    checks++; if (pushOut !== 1'b0) begin failures++; $display("FAIL lat_early got=%0b exp=0", pushOut); end
    tick();
    checks++; if (pushOut !== 1'b1) begin failures++; $display("FAIL lat_nominal got=%0b exp=1", pushOut); end
    checks++; if (dataOutI !== 24'sd2) begin failures++; $display("FAIL rnd_pos_half got=%0d exp=2", dataOutI); end
    checks++; if (dataOutQ !== 24'sd0) begin failures++; $display("FAIL rnd_below_half got=%0d exp=0", dataOutQ); end
    tick();
    checks++; if (pushOut !== 1'b0) begin failures++; $display("FAIL lat_pulse got=%0b exp=0", pushOut); end
    push(-a, mk(5) + half);
    push(mk(-5) - half, mk(7) + half - 56'sd1);
    tick();
    tick();
    checks++; if (dataOutI !== -24'sd1 || dataOutQ !== 24'sd6) begin failures++; $display("FAIL rnd_neg_half got=%0d/%0d exp=-1/6", dataOutI, dataOutQ); end
    tick();
    checks++; if (pushOut !== 1'b1 || dataOutI !== -24'sd5 || dataOutQ !== 24'sd7) begin failures++; $display("FAIL rnd_b2b got=%0b %0d/%0d exp=1 -5/7", pushOut, dataOutI, dataOutQ); end
    checks++; if (satErr !== 1'b0) begin failures++; $display("FAIL rnd_no_sat got=%0b exp=0", satErr); end
    tick();
  endtask

  task automatic test_saturation();
    logic signed [IN_W-1:0] mx;
    logic signed [IN_W-1:0] mn;
    mx = {1'b0, {(IN_W-1){1'b1}}};
    mn = {1'b1, {(IN_W-1){1'b0}}};
    push(mx, mn);
    checks++; if (satErr !== 1'b0) begin failures++; $display("FAIL sat_early got=%0b exp=0", satErr); end
    tick();
    checks++; if (satErr !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b exp=1", satErr); end
    tick();
    tick();
    checks++; if (pushOut !== 1'b1 || dataOutI !== 24'sh7FFFFF) begin failures++; $display("FAIL sat_pos got=%0b %h exp=1 7fffff", pushOut, dataOutI); end
    checks++; if (dataOutQ !== 24'sh800000) begin failures++; $display("FAIL sat_neg got=%h exp=800000", dataOutQ); end
    push(mk(3), mk(-3));
    repeat (5) tick();
    checks++; if (satErr !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0b exp=1", satErr); end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    stopIn = 1'b1;
    for (int n = 1; n <= 17; n++) push(mk(n), mk(-n));
    tick();
    checks++; if (level !== 5'd16 || ovfErr !== 1'b0) begin failures++; $display("FAIL ovf_full got level=%0d ovf=%0b exp=16/0", level, ovfErr); end
    tick();
    checks++; if (level !== 5'd16 || ovfErr !== 1'b1) begin failures++; $display("FAIL ovf_drop got level=%0d ovf=%0b exp=16/1", level, ovfErr); end
    base = out_q.size();
    stopIn = 1'b0;
    repeat (20) tick();
    checks++; if (out_q.size() - base != 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", out_q.size() - base); end
    for (int i = 0; i < 16 && base + i < out_q.size(); i++) begin
      checks++;
      if (out_q[base+i] !== {OUT_W'(i+1), OUT_W'(-(i+1))}) begin
        failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, out_q[base+i], {OUT_W'(i+1), OUT_W'(-(i+1))});
      end
    end
    checks++; if (level !== 5'd0 || ovfErr !== 1'b1) begin failures++; $display("FAIL ovf_drain got level=%0d ovf=%0b exp=0/1", level, ovfErr); end
  endtask

  task automatic test_backpressure();
    int base;
    int vbase;
    int n;
    do_reset();
    base  = out_q.size();
    vbase = stop_viol;
    n = 1;
    for (int c = 0; c < 80; c++) begin
      stopIn = ((c / 3) % 2) == 1;
      if (c % 2 == 0) begin
        pushIn = 1'b1; dataInI = mk(n); dataInQ = mk(-n); n++;
      end else begin
        pushIn = 1'b0;
      end
      tick();
    end
    pushIn = 1'b0;
    stopIn = 1'b0;
    repeat (30) tick();
    checks++; if (out_q.size() - base != 40) begin failures++; $display("FAIL bp_count got=%0d exp=40", out_q.size() - base); end
    for (int i = 0; i < 40 && base + i < out_q.size(); i++) begin
      checks++;
      if (out_q[base+i] !== {OUT_W'(i+1), OUT_W'(-(i+1))}) begin
        failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, out_q[base+i], {OUT_W'(i+1), OUT_W'(-(i+1))});
      end
    end
    checks++; if (stop_viol - vbase != 0) begin failures++; $display("FAIL bp_stop_honoured got=%0d exp=0", stop_viol - vbase); end
    checks++; if (ovfErr !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL bp_final got ovf=%0b level=%0d exp=0/0", ovfErr, level); end
  endtask

  task automatic test_full_simul_read();
    int base;
    do_reset();
    stopIn = 1'b1;
    for (int n = 1; n <= 16; n++) push(mk(n), mk(-n));
    tick();
    tick();
    checks++; if (level !== 5'd16 || ovfErr !== 1'b0) begin failures++; $display("FAIL fr_fill got level=%0d ovf=%0b exp=16/0", level, ovfErr); end
    push(mk(17), mk(-17));
    tick();
    base = out_q.size();
    stopIn = 1'b0;
    tick();
    checks++; if (level !== 5'd16 || ovfErr !== 1'b0) begin failures++; $display("FAIL fr_accept got level=%0d ovf=%0b exp=16/0", level, ovfErr); end
    checks++; if (pushOut !== 1'b1 || dataOutI !== 24'sd1) begin failures++; $display("FAIL fr_head got=%0b %0d exp=1 1", pushOut, dataOutI); end
    stopIn = 1'b1;
    tick();
    checks++; if (pushOut !== 1'b0 || level !== 5'd16) begin failures++; $display("FAIL fr_hold got=%0b level=%0d exp=0/16", pushOut, level); end
    stopIn = 1'b0;
    repeat (20) tick();
    checks++; if (out_q.size() - base != 17) begin failures++; $display("FAIL fr_count got=%0d exp=17", out_q.size() - base); end
    for (int i = 0; i < 17 && base + i < out_q.size(); i++) begin
      checks++;
      if (out_q[base+i] !== {OUT_W'(i+1), OUT_W'(-(i+1))}) begin
        failures++; $display("FAIL fr_data[%0d] got=%h exp=%h", i, out_q[base+i], {OUT_W'(i+1), OUT_W'(-(i+1))});
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int base;
    logic signed [IN_W-1:0] mx;
    mx = {1'b0, {(IN_W-1){1'b1}}};
    do_reset();
    stopIn = 1'b1;
    push(mx, mk(-1));
    for (int n = 2; n <= 7; n++) push(mk(n), mk(-n));
    checks++; if (level !== 5'd5 || satErr !== 1'b1) begin failures++; $display("FAIL mr_pre got level=%0d sat=%0b exp=5/1", level, satErr); end
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    stopIn = 1'b0;
    checks++; if (pushOut !== 1'b0 || level !== 5'd0) begin failures++; $display("FAIL mr_clear got=%0b level=%0d exp=0/0", pushOut, level); end
    checks++; if (ovfErr !== 1'b0 || satErr !== 1'b0) begin failures++; $display("FAIL mr_flags got ovf=%0b sat=%0b exp=0/0", ovfErr, satErr); end
    base = out_q.size();
    repeat (6) tick();
    checks++; if (out_q.size() != base || level !== 5'd0) begin failures++; $display("FAIL mr_discard got outs=%0d level=%0d exp=0/0", out_q.size() - base, level); end
    push(mk(9), mk(-9));
    tick();
    tick();
    checks++; if (pushOut !== 1'b0) begin failures++; $display("FAIL mr_lat_early got=%0b exp=0", pushOut); end
    tick();
    checks++; if (pushOut !== 1'b1 || dataOutI !== 24'sd9 || dataOutQ !== -24'sd9) begin failures++; $display("FAIL mr_new got=%0b %0d/%0d exp=1 9/-9", pushOut, dataOutI, dataOutQ); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_backpressure();
    test_full_simul_read();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
